// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: select-width helper and
// the routing classification of an input word.
package stream_demux_pkg;

  // Select width for N channels; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    ROUTE_UNICAST = 2'd0,
    ROUTE_BCAST   = 2'd1,
    ROUTE_DROP    = 2'd2
  } route_e;

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side handshake bundle of the stream demultiplexer.
// master = producer plus consumers, slave = the demultiplexer.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) ();

  localparam int SEL_W = sel_w(N);

  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_bcast;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/demux_chan_reg.sv
// One-word holding register for a single output channel: loads a new word,
// presents it until the consumer accepts, and may reload while draining.
module demux_chan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples pre-edge values; the data register is reset too so
  // out_data is a known value straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      // Load wins over drain: a same-cycle drain and load leaves no bubble.
      valid_q <= 1'b1;
      data_q  <= data;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: unicast by in_sel, broadcast to all
// channels, or discard-and-count when in_sel addresses a missing channel.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int SEL_W = sel_w(N);
  // N always fits in SEL_W+1 bits, so the range test needs no wider compare.
  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

  route_e         route;
  logic [N-1:0]   free;
  logic [N-1:0]   sel_hit;
  logic [N-1:0]   load;
  logic           in_rdy;
  logic           xfer;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    route = ROUTE_UNICAST;
    if (bus.in_bcast) begin
      route = ROUTE_BCAST;
    end else if ({1'b0, bus.in_sel} >= N_EXT) begin
      route = ROUTE_DROP;
    end
  end

  always_comb begin
    free    = '0;
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      free[k]    = !bus.out_valid[k] || bus.out_ready[k];
      sel_hit[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  // in_ready depends only on channel state, select and broadcast, never on in_valid.
  always_comb begin
    in_rdy = 1'b1;
    unique case (route)
      ROUTE_BCAST:   in_rdy = &free;
      ROUTE_UNICAST: in_rdy = |(sel_hit & free);
      default:       in_rdy = 1'b1;
    endcase
  end

  assign bus.in_ready = in_rdy;
  assign xfer         = bus.in_valid && in_rdy;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = xfer && ((route == ROUTE_BCAST) ||
                         ((route == ROUTE_UNICAST) && sel_hit[k]));
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_chan
    demux_chan_reg #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .data      (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .valid_q   (bus.out_valid[k]),
      .data_q    (bus.out_data[k*WIDTH +: WIDTH])
    );
  end

  // Saturating count of words discarded for an out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (xfer && (route == ROUTE_DROP) && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus a randomized
// run scored against per-channel FIFO-of-pending-words reference model.
module tb_stream_demux;

  logic clk;
  logic rst_n;
  logic [7:0] drop4;
  logic [7:0] drop3;

  int checks   = 0;
  int failures = 0;

  stream_demux_if #(.N(4), .WIDTH(8)) bus4 ();
  stream_demux_if #(.N(3), .WIDTH(8)) bus3 ();

  stream_demux #(.N(4), .WIDTH(8), .CNT_W(8)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus4.slave),
    .drop_cnt (drop4)
  );

  stream_demux #(.N(3), .WIDTH(8), .CNT_W(8)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus3.slave),
    .drop_cnt (drop3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: words accepted for each channel and not yet consumed.
  logic [7:0] mq [4][$];
  logic       stalled4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the N=4 instance: check outputs against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic cycle4();
    logic [3:0] fr;
    logic       exp_rdy;
    logic       xf;
    @(negedge clk);
    for (int k = 0; k < 4; k++) fr[k] = (mq[k].size() == 0) || bus4.out_ready[k];
    exp_rdy = bus4.in_bcast ? &fr : fr[bus4.in_sel];
    chk("in_ready", 32'(bus4.in_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid[%0d]", k), 32'(bus4.out_valid[k]), 32'(mq[k].size() != 0));
      if (mq[k].size() != 0)
        chk($sformatf("out_data[%0d]", k), 32'(bus4.out_data[k*8 +: 8]), 32'(mq[k][0]));
    end
    chk("drop_cnt4", 32'(drop4), 32'd0);
    xf = bus4.in_valid && exp_rdy;
    stalled4 = bus4.in_valid && !exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0 && bus4.out_ready[k]) void'(mq[k].pop_front());
      if (xf && (bus4.in_bcast || bus4.in_sel == 2'(k))) mq[k].push_back(bus4.in_data);
    end
    #1;
  endtask

  task automatic send4(input logic bc, input logic [1:0] sel, input logic [7:0] d);
    bus4.in_bcast = bc;
    bus4.in_sel   = sel;
    bus4.in_data  = d;
    bus4.in_valid = 1'b1;
    cycle4();
  endtask

  task automatic idle4(input int n);
    bus4.in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle4();
  endtask

  initial begin
    rst_n = 1'b0;
    stalled4 = 1'b0;
    bus4.in_data = '0; bus4.in_sel = '0; bus4.in_bcast = 1'b0; bus4.in_valid = 1'b0;
    bus4.out_ready = 4'b1111;
    bus3.in_data = '0; bus3.in_sel = '0; bus3.in_bcast = 1'b0; bus3.in_valid = 1'b0;
    bus3.out_ready = 3'b111;

    // Reset state
    #3;
    chk("rst out_valid", 32'(bus4.out_valid), 32'h0);
    chk("rst out_data", 32'(bus4.out_data), 32'h0);
    chk("rst drop_cnt", 32'(drop4), 32'h0);
    chk("rst out_valid3", 32'(bus3.out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unicast sweep
    for (int k = 0; k < 4; k++) begin
      send4(1'b0, 2'(k), 8'hA0 + 8'(k));
      chk("sweep valid", 32'(bus4.out_valid), 32'(4'b0001 << k));
      chk("sweep data", 32'(bus4.out_data[k*8 +: 8]), 32'(8'hA0 + 8'(k)));
    end
    idle4(2);

    // Backpressure on channel 2 while channel 1 keeps flowing
    bus4.out_ready = 4'b1011;
    send4(1'b0, 2'd2, 8'h55);
    send4(1'b0, 2'd1, 8'h77);
    chk("bp ch1 valid", 32'(bus4.out_valid[1]), 32'd1);
    chk("bp ch1 data", 32'(bus4.out_data[15:8]), 32'h77);
    send4(1'b0, 2'd2, 8'h66);
    chk("bp stall ready", 32'(bus4.in_ready), 32'd0);
    chk("bp ch2 hold", 32'(bus4.out_data[23:16]), 32'h55);
    cycle4();
    chk("bp ch2 still 55", 32'(bus4.out_data[23:16]), 32'h55);
    bus4.out_ready = 4'b1111;
    cycle4();
    chk("bp ch2 valid", 32'(bus4.out_valid[2]), 32'd1);
    chk("bp ch2 new", 32'(bus4.out_data[23:16]), 32'h66);
    idle4(2);

    // Broadcast, then broadcast blocked by a stalled channel
    send4(1'b1, 2'd0, 8'hC3);
    chk("bc valid", 32'(bus4.out_valid), 32'hF);
    for (int k = 0; k < 4; k++) chk("bc data", 32'(bus4.out_data[k*8 +: 8]), 32'hC3);
    bus4.in_valid = 1'b0;
    bus4.out_ready = 4'b0111;
    cycle4();
    chk("bc ch3 only", 32'(bus4.out_valid), 32'h8);
    send4(1'b1, 2'd0, 8'h3C);
    chk("bc blocked valid", 32'(bus4.out_valid), 32'h8);
    chk("bc blocked ch3", 32'(bus4.out_data[31:24]), 32'hC3);
    bus4.out_ready = 4'b1111;
    bus4.in_valid = 1'b0;
    idle4(2);

    // Out-of-range select on the N=3 build
    bus3.in_sel = 2'd3;
    bus3.in_data = 8'h99;
    bus3.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("oor in_ready", 32'(bus3.in_ready), 32'd1);
      chk("oor out_valid", 32'(bus3.out_valid), 32'd0);
      chk("oor drop_cnt", 32'(drop3), 32'((i > 255) ? 255 : i));
      @(posedge clk);
      #1;
    end
    bus3.in_valid = 1'b0;
    @(negedge clk);
    chk("oor saturated", 32'(drop3), 32'd255);
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer back-pressure
    for (int i = 0; i < 10000; i++) begin
      if (!stalled4) begin
        bus4.in_valid = ($urandom_range(0, 3) != 0);
        bus4.in_sel   = 2'($urandom_range(0, 3));
        bus4.in_bcast = ($urandom_range(0, 7) == 0);
        bus4.in_data  = 8'($urandom);
      end
      for (int k = 0; k < 4; k++) bus4.out_ready[k] = ($urandom_range(0, 3) != 0);
      cycle4();
    end
    bus4.out_ready = 4'b1111;
    idle4(3);

    // Reset mid-run with words buffered in every channel
    bus4.out_ready = 4'b0000;
    send4(1'b1, 2'd0, 8'h5A);
    bus4.in_valid = 1'b0;
    chk("pre-rst valid", 32'(bus4.out_valid), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus4.out_valid), 32'h0);
    chk("midrst out_data", 32'(bus4.out_data), 32'h0);
    chk("midrst drop3", 32'(drop3), 32'h0);
    chk("midrst valid3", 32'(bus3.out_valid), 32'h0);
    for (int k = 0; k < 4; k++) mq[k].delete();
    stalled4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus4.out_ready = 4'b1111;
    @(posedge clk);
    #1;
    send4(1'b0, 2'd3, 8'hE7);
    idle4(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
